// File: rtl/dyser_in_port_pkg.sv
// Shared types for the DySER input port: the buffered word (data plus valid/phi tag)
// and the system-level sizing knobs that normally come from dyser_config.v.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DYSER_INPORT_DEPTH
`define DYSER_INPORT_DEPTH 4
`endif

package dyser_in_port_pkg;

  localparam int DW            = `DATA_WIDTH;
  localparam int DEFAULT_DEPTH = `DYSER_INPORT_DEPTH;

  typedef struct packed {
    logic          valid;
    logic [DW:0]   data;
  } port_word_t;

  localparam int WORD_W = $bits(port_word_t);

endpackage

// File: rtl/dyser_port_fifo.sv
// Generic DEPTH x W circular buffer with pointers, occupancy count and full/empty flags.
// Also exposes the entry after the head and the next-cycle count for registered consumers.
module dyser_port_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  head_nxt_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   count_nxt_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o & ~clr_i;
  assign pop_ok  = pop_i & ~empty_o & ~clr_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_nxt_o  = mem_q[rd_ptr_q + AW'(1)];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;

endmodule

// File: rtl/dyser_in_port.sv
// Sender end of the DySER ready/credit link: buffers core operand words and presents the
// head word to the first fabric stage with registered ready/data/valid outputs.
module dyser_in_port
  import dyser_in_port_pkg::*;
#(
  parameter int ID    = 0,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [`DATA_WIDTH:0]   wr_data,
  input  logic                   wr_valid,
  output logic                   wr_rdy,
  input  logic                   flush,
  input  logic                   credit_in,
  output logic                   ready_out,
  output logic [`DATA_WIDTH:0]   data_out,
  output logic                   valid_out,
  output logic [AW:0]            count,
  output logic                   overflow
);

  if (AW != $clog2(DEPTH) || DEPTH < 2 || DEPTH > 16 || ID < 0) begin : g_bad_cfg
    $error("dyser_in_port: DEPTH must be a power of two in 2..16 with AW = log2(DEPTH)");
  end

  port_word_t  wr_word, nxt_word, out_q, out_d;
  logic        ready_q, ready_d;
  logic        overflow_q, overflow_d;
  logic        push, pop, full, empty;
  logic [AW:0] cnt, cnt_nxt;

  assign wr_word = '{valid: wr_valid, data: wr_data};
  assign push    = wr_en & ~full & ~flush;
  assign pop     = ready_q & credit_in & ~flush;

  dyser_port_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (flush),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (wr_word),
    .head_nxt_o  (nxt_word),
    .count_o     (cnt),
    .count_nxt_o (cnt_nxt),
    .full_o      (full),
    .empty_o     (empty)
  );

  // The output register must already hold the next head after each edge: the incoming
  // word when the FIFO is (or becomes) otherwise empty, else the entry behind the popped head.
  always_comb begin
    out_d      = out_q;
    ready_d    = (cnt_nxt != '0);
    overflow_d = overflow_q | (wr_en & full);
    if (!flush) begin
      if (push && (empty || (pop && cnt == (AW+1)'(1)))) begin
        out_d = wr_word;
      end else if (pop && cnt > (AW+1)'(1)) begin
        out_d = nxt_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_rdy    = ~full;
  assign ready_out = ready_q;
  assign data_out  = out_q.data;
  assign valid_out = out_q.valid;
  assign count     = cnt;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dyser_in_port.sv
// Scenario bench for dyser_in_port: words accepted by the link model are queued as
// expectations and checked when the fabric side takes them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_dyser_in_port;

  localparam int DW    = `DATA_WIDTH;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = DW + 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW:0]   wr_data;
  logic          wr_valid;
  logic          wr_rdy;
  logic          flush;
  logic          credit_in;
  logic          ready_out;
  logic [DW:0]   data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          overflow;

  logic [W-1:0]  exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            xfers = 0;
  bit            m_ovf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dyser_in_port #(.ID(0), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_rdy    (wr_rdy),
    .flush     (flush),
    .credit_in (credit_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .count     (count),
    .overflow  (overflow)
  );

  // One clock cycle: predict the edge from the model, check any transfer, update the model.
  task automatic tick();
    int           sz;
    logic         do_pop, do_push;
    logic [W-1:0] got, exp_w;
    @(negedge clk);
    sz      = exp_q.size();
    do_pop  = rst_n && !flush && sz > 0 && credit_in;
    do_push = rst_n && !flush && wr_en && sz < DEPTH;
    if (rst_n && wr_en && sz == DEPTH) m_ovf = 1'b1;
    if (do_pop) begin
      got   = {valid_out, data_out};
      exp_w = exp_q.pop_front();
      total++;
      if (ready_out !== 1'b1 || got !== exp_w) begin
        bad++;
        $display("FAIL sb_pop: ready_out=%b got=%h expected=%h", ready_out, got, exp_w);
      end
      xfers++;
    end
    @(posedge clk);
    if (!rst_n || flush) begin
      exp_q.delete();
      if (!rst_n) m_ovf = 1'b0;
    end else if (do_push) begin
      exp_q.push_back({wr_valid, wr_data});
    end
    #1;
  endtask

  task automatic push_word(input logic [DW:0] d, input logic v);
    wr_en    = 1'b1;
    wr_data  = d;
    wr_valid = v;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic drain(output int n);
    n         = 0;
    wr_en     = 1'b0;
    credit_in = 1'b1;
    while (exp_q.size() != 0 && n < 32) begin
      tick();
      n++;
    end
    credit_in = 1'b0;
  endtask

  task automatic do_reset();
    wr_en     = 1'b0;
    credit_in = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    wr_en     = 1'b1;
    wr_data   = (DW+1)'(32'h55);
    wr_valid  = 1'b1;
    credit_in = 1'b1;
    repeat (3) tick();
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready: got=%b expected=0", ready_out); end
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count: got=%0d expected=0", count); end
    total++; if (wr_rdy !== 1'b1) begin bad++; $display("FAIL rst_wr_rdy: got=%b expected=1", wr_rdy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got=%b expected=0", overflow); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL rst_data: got=%h expected=0", data_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%b expected=0", valid_out); end
    wr_en     = 1'b0;
    credit_in = 1'b0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_single();
    credit_in = 1'b0;
    push_word((DW+1)'(32'h11), 1'b1);
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL single_ready: got=%b expected=1", ready_out); end
    total++; if (data_out !== (DW+1)'(32'h11) || valid_out !== 1'b1) begin
      bad++; $display("FAIL single_head: got=%h/%b expected=11/1", data_out, valid_out);
    end
    total++; if (count !== (AW+1)'(1)) begin bad++; $display("FAIL single_count: got=%0d expected=1", count); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ready_out !== 1'b1 || data_out !== (DW+1)'(32'h11)) begin
        bad++; $display("FAIL single_hold: cycle=%0d ready=%b data=%h expected 1/11", i, ready_out, data_out);
      end
    end
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL single_pop_ready: got=%b expected=0", ready_out); end
    total++; if (count !== '0) begin bad++; $display("FAIL single_pop_count: got=%0d expected=0", count); end
  endtask

  task automatic test_fill_overflow();
    int n;
    int start;
    credit_in = 1'b0;
    for (int i = 1; i <= 5; i++) push_word((DW+1)'(i), 1'b1);
    total++; if (count !== (AW+1)'(DEPTH)) begin bad++; $display("FAIL fill_count: got=%0d expected=%0d", count, DEPTH); end
    total++; if (wr_rdy !== 1'b0) begin bad++; $display("FAIL fill_wr_rdy: got=%b expected=0", wr_rdy); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow: got=%b expected=1", overflow); end
    start = xfers;
    drain(n);
    total++; if (n != 4 || xfers - start != 4) begin
      bad++; $display("FAIL fill_drain: cycles=%0d transfers=%0d expected 4/4", n, xfers - start);
    end
    total++; if (ready_out !== 1'b0 || count !== '0) begin
      bad++; $display("FAIL fill_empty: ready=%b count=%0d expected 0/0", ready_out, count);
    end
  endtask

  task automatic test_streaming();
    int n;
    int start;
    do_reset();
    start     = xfers;
    credit_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en    = 1'b1;
      wr_data  = (DW+1)'(32'hA0 + i);
      wr_valid = i[0];
      tick();
      total++;
      if (count > (AW+1)'(1)) begin bad++; $display("FAIL stream_count: i=%0d got=%0d expected<=1", i, count); end
    end
    drain(n);
    total++; if (xfers - start != 16) begin bad++; $display("FAIL stream_xfers: got=%0d expected=16", xfers - start); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stream_overflow: got=%b expected=0", overflow); end
  endtask

  task automatic test_credit_toggle();
    logic      pat [5];
    int        exp_cnt [5];
    pat     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_cnt = '{2, 2, 1, 1, 0};
    credit_in = 1'b0;
    push_word((DW+1)'(32'h31), 1'b1);
    push_word((DW+1)'(32'h32), 1'b0);
    push_word((DW+1)'(32'h33), 1'b1);
    for (int i = 0; i < 5; i++) begin
      credit_in = pat[i];
      tick();
      total++;
      if (count !== (AW+1)'(exp_cnt[i])) begin
        bad++; $display("FAIL toggle_count: cycle=%0d got=%0d expected=%0d", i + 1, count, exp_cnt[i]);
      end
    end
    credit_in = 1'b0;
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL toggle_ready: got=%b expected=0", ready_out); end
  endtask

  task automatic test_back_to_back();
    int n;
    credit_in = 1'b0;
    for (int i = 0; i < 3; i++) push_word((DW+1)'(32'h40 + i), 1'b1);
    credit_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en    = 1'b1;
      wr_data  = (DW+1)'(32'h50 + i);
      wr_valid = 1'b1;
      tick();
      total++;
      if (count !== (AW+1)'(DEPTH - 1)) begin bad++; $display("FAIL b2b_count: i=%0d got=%0d expected=3", i, count); end
    end
    credit_in = 1'b0;
    push_word((DW+1)'(32'h60), 1'b0);
    credit_in = 1'b1;
    push_word((DW+1)'(32'hEE), 1'b1);
    credit_in = 1'b0;
    total++; if (count !== (AW+1)'(DEPTH - 1)) begin bad++; $display("FAIL nobypass_count: got=%0d expected=3", count); end
    total++; if (overflow !== m_ovf || m_ovf !== 1'b1) begin
      bad++; $display("FAIL nobypass_overflow: got=%b expected=1", overflow);
    end
    drain(n);
    total++; if (n != 3) begin bad++; $display("FAIL b2b_drain: cycles=%0d expected=3", n); end
  endtask

  task automatic test_flush();
    int n;
    do_reset();
    credit_in = 1'b0;
    for (int i = 0; i < 3; i++) push_word((DW+1)'(32'h21 + i), 1'b1);
    flush     = 1'b1;
    wr_en     = 1'b1;
    wr_data   = (DW+1)'(32'h99);
    credit_in = 1'b1;
    tick();
    flush     = 1'b0;
    wr_en     = 1'b0;
    credit_in = 1'b0;
    total++; if (count !== '0 || ready_out !== 1'b0) begin
      bad++; $display("FAIL flush_clear: count=%0d ready=%b expected 0/0", count, ready_out);
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf_low: got=%b expected=0", overflow); end
    push_word((DW+1)'(32'h7), 1'b1);
    total++; if (ready_out !== 1'b1 || data_out !== (DW+1)'(32'h7)) begin
      bad++; $display("FAIL flush_repush: ready=%b data=%h expected 1/7", ready_out, data_out);
    end
    drain(n);
    for (int i = 0; i < 5; i++) push_word((DW+1)'(32'h80 + i), 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL flush_ovf_kept: got=%b expected=1", overflow); end
    total++; if (count !== '0 || wr_rdy !== 1'b1) begin
      bad++; $display("FAIL flush_full_clear: count=%0d wr_rdy=%b expected 0/1", count, wr_rdy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    credit_in = 1'b0;
    push_word((DW+1)'(32'h61), 1'b1);
    push_word((DW+1)'(32'h62), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ovf = 1'b0;
    total++; if (ready_out !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
      bad++; $display("FAIL midrst_async: ready=%b count=%0d ovf=%b expected 0/0/0", ready_out, count, overflow);
    end
    wr_en     = 1'b1;
    wr_data   = (DW+1)'(32'h77);
    credit_in = 1'b1;
    repeat (2) tick();
    wr_en     = 1'b0;
    rst_n     = 1'b1;
    repeat (2) tick();
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL midrst_hold: got=%b expected=0", ready_out); end
    credit_in = 1'b0;
    push_word((DW+1)'(32'h5A), 1'b0);
    total++; if (ready_out !== 1'b1 || data_out !== (DW+1)'(32'h5A) || valid_out !== 1'b0) begin
      bad++; $display("FAIL midrst_push: ready=%b data=%h valid=%b expected 1/5a/0", ready_out, data_out, valid_out);
    end
    drain(n);
  endtask

  task automatic test_random();
    int n;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      wr_en     = ($urandom_range(0, 99) < 60);
      credit_in = ($urandom_range(0, 99) < 50);
      wr_data   = (DW+1)'({$urandom(), $urandom()});
      wr_valid  = $urandom_range(0, 1) != 0;
      tick();
      total++;
      if (count !== (AW+1)'(exp_q.size()) || overflow !== m_ovf || wr_rdy !== (exp_q.size() < DEPTH)) begin
        bad++;
        $display("FAIL rand_state: i=%0d count=%0d ovf=%b wr_rdy=%b expected %0d/%b/%b",
                 i, count, overflow, wr_rdy, exp_q.size(), m_ovf, exp_q.size() < DEPTH);
      end
    end
    drain(n);
    total++; if (exp_q.size() != 0 || ready_out !== 1'b0) begin
      bad++; $display("FAIL rand_drain: left=%0d ready=%b expected 0/0", exp_q.size(), ready_out);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    flush     = 1'b0;
    credit_in = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_streaming();
    test_credit_toggle();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
